// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RISC-V M-extension multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_mul(input op_e op);
    return !op[2];
  endfunction

  function automatic logic rs1_signed(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic rs2_signed(input op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle of the multiply/divide unit; the unit sits on the slave side.
interface muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [4:0]      i_rd_addr;
  logic            i_flush;
  logic            o_valid;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd_addr;
  logic            o_busy;

  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_rd_addr, i_flush,
    input  o_ready, o_valid, o_result, o_rd_addr, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_rd_addr, i_flush,
    output o_ready, o_valid, o_result, o_rd_addr, o_busy
  );
endinterface

// File: rtl/muldiv_unit_iter_divider.sv
// Restoring unsigned divider, one quotient bit per step; exposes the post-step
// values so the caller can capture the final result on the last step edge.
module iter_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot_next,
  output logic [XLEN-1:0] o_rem_next
);
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  // r_quot starts as the dividend and fills with quotient bits from the right.
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};

  always_comb begin
    if (!w_diff[XLEN]) begin
      o_rem_next  = w_diff[XLEN-1:0];
      o_quot_next = {r_quot[XLEN-2:0], 1'b1};
    end else begin
      o_rem_next  = w_shift[XLEN-1:0];
      o_quot_next = {r_quot[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (i_load) begin
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
    end else if (i_step) begin
      r_quot    <= o_quot_next;
      r_rem     <= o_rem_next;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit: iterative shift-add multiply (or
// single-cycle when FAST_MUL=1), restoring divide, single-cycle special cases.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int FAST_MUL = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);

  state_e            r_state, w_state_next;
  op_e               w_op, r_op;
  logic [CW-1:0]     r_cnt;
  logic [4:0]        r_tag, r_rd_addr;
  logic [XLEN-1:0]   r_result, r_mcand;
  logic [2*XLEN-1:0] r_prod;
  logic              r_neg_q, r_neg_r;

  logic              w_accept, w_fast, w_div_zero, w_overflow, w_last, w_step;
  logic              w_sign1, w_sign2;
  logic [XLEN-1:0]   w_abs1, w_abs2, w_fast_result, w_final, w_quot_next, w_rem_next;
  logic [2*XLEN-1:0] w_fast_prod, w_prod_next, w_prod_signed;
  logic [XLEN:0]     w_add;

  assign w_op       = op_e'(bus.i_op);
  assign w_accept   = bus.i_valid && (r_state == ST_IDLE) && !bus.i_flush;
  assign w_step     = (r_state == ST_CALC) && !bus.i_flush;
  assign w_last     = (r_cnt == CW'(1));
  assign w_sign1    = rs1_signed(w_op) && bus.i_rs1[XLEN-1];
  assign w_sign2    = rs2_signed(w_op) && bus.i_rs2[XLEN-1];
  assign w_abs1     = w_sign1 ? -bus.i_rs1 : bus.i_rs1;
  assign w_abs2     = w_sign2 ? -bus.i_rs2 : bus.i_rs2;
  assign w_div_zero = (bus.i_rs2 == '0);
  assign w_overflow = (w_op == OP_DIV || w_op == OP_REM) &&
                      (bus.i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_rs2 == '1);
  assign w_fast     = op_is_mul(w_op) ? (FAST_MUL != 0) : (w_div_zero || w_overflow);

  // Extending each operand to 2*XLEN with its own signedness makes one multiplier
  // cover all four multiply flavours.
  if (FAST_MUL != 0) begin : g_fast_mul
    assign w_fast_prod = {{XLEN{w_sign1}}, bus.i_rs1} * {{XLEN{w_sign2}}, bus.i_rs2};
  end else begin : g_no_fast_mul
    assign w_fast_prod = '0;
  end

  always_comb begin
    w_fast_result = '0;
    case (w_op)
      OP_MUL:                       w_fast_result = w_fast_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fast_result = w_fast_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fast_result = w_div_zero ? '1 : bus.i_rs1;
      default:                      w_fast_result = w_div_zero ? bus.i_rs1 : '0;
    endcase
  end

  // Shift-add on magnitudes: multiplier sits in the low half and drains out right.
  assign w_add         = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_next   = {w_add, r_prod[XLEN-1:1]};
  assign w_prod_signed = r_neg_q ? -w_prod_next : w_prod_next;

  iter_divider #(.XLEN(XLEN)) u_div (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_accept && !op_is_mul(w_op)),
    .i_step      (w_step && !op_is_mul(r_op)),
    .i_dividend  (w_abs1),
    .i_divisor   (w_abs2),
    .o_quot_next (w_quot_next),
    .o_rem_next  (w_rem_next)
  );

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod_signed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_signed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = r_neg_q ? -w_quot_next : w_quot_next;
      default:                      w_final = r_neg_r ? -w_rem_next : w_rem_next;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.i_flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_next = w_fast ? ST_DONE : ST_CALC;
        ST_CALC: if (w_last)   w_state_next = ST_DONE;
        ST_DONE:               w_state_next = ST_IDLE;
        default:               w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_op      <= OP_MUL;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_result  <= '0;
      r_rd_addr <= '0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_tag   <= bus.i_rd_addr;
      r_cnt   <= w_fast ? '0 : CW'(XLEN);
      r_neg_q <= w_sign1 ^ w_sign2;
      r_neg_r <= w_sign1;
      r_mcand <= w_abs1;
      r_prod  <= {{XLEN{1'b0}}, w_abs2};
      if (w_fast) begin
        r_result  <= w_fast_result;
        r_rd_addr <= bus.i_rd_addr;
      end
    end else if (w_step) begin
      r_cnt <= r_cnt - CW'(1);
      if (op_is_mul(r_op)) r_prod <= w_prod_next;
      if (w_last) begin
        r_result  <= w_final;
        r_rd_addr <= r_tag;
      end
    end
  end

  assign bus.o_ready   = (r_state == ST_IDLE);
  assign bus.o_busy    = (r_state == ST_CALC) || (r_state == ST_DONE);
  assign bus.o_valid   = (r_state == ST_DONE) && !bus.i_flush;
  assign bus.o_result  = r_result;
  assign bus.o_rd_addr = r_rd_addr;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: 32-bit iterative, 32-bit fast-multiply and 16-bit instances.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) if0 ();
  muldiv_unit_if #(.XLEN(32)) if1 ();
  muldiv_unit_if #(.XLEN(16)) if2 ();

  muldiv_unit #(.XLEN(32), .FAST_MUL(0)) dut0 (.i_clk(clk), .i_reset(rst_n), .bus(if0));
  muldiv_unit #(.XLEN(32), .FAST_MUL(1)) dut1 (.i_clk(clk), .i_reset(rst_n), .bus(if1));
  muldiv_unit #(.XLEN(16), .FAST_MUL(0)) dut2 (.i_clk(clk), .i_reset(rst_n), .bus(if2));

  typedef struct {
    int          d;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic fl);
    case (d)
      0: begin
        if0.i_valid = v; if0.i_op = op; if0.i_rs1 = a; if0.i_rs2 = b;
        if0.i_rd_addr = tag; if0.i_flush = fl;
      end
      1: begin
        if1.i_valid = v; if1.i_op = op; if1.i_rs1 = a; if1.i_rs2 = b;
        if1.i_rd_addr = tag; if1.i_flush = fl;
      end
      default: begin
        if2.i_valid = v; if2.i_op = op; if2.i_rs1 = a[15:0]; if2.i_rs2 = b[15:0];
        if2.i_rd_addr = tag; if2.i_flush = fl;
      end
    endcase
  endtask

  function automatic logic get_valid(input int d);
    case (d)
      0: return if0.o_valid;
      1: return if1.o_valid;
      default: return if2.o_valid;
    endcase
  endfunction

  function automatic logic [31:0] get_result(input int d);
    case (d)
      0: return if0.o_result;
      1: return if1.o_result;
      default: return {16'h0, if2.o_result};
    endcase
  endfunction

  function automatic logic [4:0] get_tag(input int d);
    case (d)
      0: return if0.o_rd_addr;
      1: return if1.o_rd_addr;
      default: return if2.o_rd_addr;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int xl);
    return (xl == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Reference: RISC-V M-extension semantics in 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input int xl, input logic [2:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask;
    logic [63:0] pu;
    longint ua, ub, sa, sb, one, r, minv;
    logic ovf;
    one  = 1;
    mask = mask_of(xl);
    ua   = longint'({32'h0, a & mask});
    ub   = longint'({32'h0, b & mask});
    sa   = (ua >= (one << (xl - 1))) ? ua - (one << xl) : ua;
    sb   = (ub >= (one << (xl - 1))) ? ub - (one << xl) : ub;
    minv = -(one << (xl - 1));
    ovf  = (sa == minv) && (sb == -1);
    r    = 0;
    pu   = '0;
    case (op)
      3'd0, 3'd1: pu = 64'(sa * sb);
      3'd2:       pu = 64'(sa * ub);
      3'd3:       pu = 64'(ua * ub);
      3'd4:       r = (ub == 0) ? -1 : (ovf ? sa : sa / sb);
      3'd5:       r = (ub == 0) ? -1 : ua / ub;
      3'd6:       r = (ub == 0) ? sa : (ovf ? 0 : sa % sb);
      default:    r = (ub == 0) ? ua : ua % ub;
    endcase
    if (op == 3'd0) return pu[31:0] & mask;
    if (op < 3'd4)  return pu[xl +: 32] & mask;
    return 32'(r) & mask;
  endfunction

  function automatic int ref_lat(input int xl, input bit fast_mul, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask;
    mask = mask_of(xl);
    if (op < 3'd4) return fast_mul ? 1 : xl + 1;
    if ((b & mask) == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && ((a & mask) == (32'h1 << (xl - 1))) && ((b & mask) == mask))
      return 1;
    return xl + 1;
  endfunction

  function automatic logic [31:0] pick(input int xl);
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0:       v = 32'h0;
      1:       v = 32'h1 << (xl - 1);
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v & mask_of(xl);
  endfunction

  // Drive one request and follow it to its result; latency counts rising edges
  // from the accept edge to the first edge at which o_valid is seen high.
  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int          lat;
    logic [31:0] res;
    logic [4:0]  rtag;
    lat  = 0;
    res  = '0;
    rtag = '0;
    set_in(d, 1'b1, op, a, b, tag, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 80 && lat == 0; k++) begin
      @(negedge clk);
      if (get_valid(d)) begin
        lat  = k;
        res  = get_result(d);
        rtag = get_tag(d);
        set_in(d, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
      end else begin
        // Junk requests while busy must be ignored.
        set_in(d, 1'b1, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'b0);
      end
    end
    set_in(d, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      chk({name, " result"}, res, exp);
      chk({name, " tag"}, {27'h0, rtag}, {27'h0, tag});
    end
    @(negedge clk);
    chk({name, " single pulse"}, {31'h0, get_valid(d)}, 32'h0);
    $display("txn %s dut=%0d op=%0d rs1=%h rs2=%h tag=%0d result=%h lat=%0d",
             name, d, op, a, b, tag, res, lat);
  endtask

  task automatic expect_no_valid(input int d, input int cycles, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (get_valid(d)) seen++;
    end
    chk(name, 32'(seen), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back('{0, OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, "MUL 7x-3"});
    vecs.push_back('{0, OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33, "MULH min^2"});
    vecs.push_back('{0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33, "MULHU max^2"});
    vecs.push_back('{0, OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 33, "MULHSU -1x2"});
    vecs.push_back('{0, OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33, "DIV -7/2"});
    vecs.push_back('{0, OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33, "REM -7/2"});
    vecs.push_back('{0, OP_DIVU,   32'd100,       32'd7,         5'd11, 32'd14,        33, "DIVU 100/7"});
    vecs.push_back('{0, OP_REMU,   32'd100,       32'd7,         5'd12, 32'd2,         33, "REMU 100/7"});
    vecs.push_back('{0, OP_DIV,    32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1,  "DIV 5/0"});
    vecs.push_back('{0, OP_REM,    32'd5,         32'd0,         5'd14, 32'd5,         1,  "REM 5/0"});
    vecs.push_back('{0, OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1,  "DIV ovf"});
    vecs.push_back('{0, OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0,         1,  "REM ovf"});
    vecs.push_back('{0, OP_DIVU,   32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1,  "DIVU 5/0"});
    vecs.push_back('{0, OP_REMU,   32'd5,         32'd0,         5'd18, 32'd5,         1,  "REMU 5/0"});
    vecs.push_back('{1, OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd19, 32'h4000_0000, 1,  "fast MULH"});
    vecs.push_back('{1, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFE, 1,  "fast MULHU"});
    vecs.push_back('{1, OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd21, 32'hFFFF_FFFF, 1,  "fast MULHSU"});
    vecs.push_back('{1, OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd22, 32'hFFFF_FFEB, 1,  "fast MUL"});
    vecs.push_back('{1, OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd23, 32'hFFFF_FFFD, 33, "fast-unit DIV"});
    vecs.push_back('{2, OP_DIVU,   32'h0000_FFFF, 32'h0000_0010, 5'd24, 32'h0000_0FFF, 17, "x16 DIVU"});
    vecs.push_back('{2, OP_REMU,   32'h0000_FFFF, 32'h0000_0010, 5'd25, 32'h0000_000F, 17, "x16 REMU"});
    vecs.push_back('{2, OP_MULH,   32'h0000_8000, 32'h0000_8000, 5'd26, 32'h0000_4000, 17, "x16 MULH"});
    vecs.push_back('{2, OP_DIV,    32'h0000_8000, 32'h0000_FFFF, 5'd27, 32'h0000_8000, 1,  "x16 DIV ovf"});

    for (int d = 0; d < 3; d++) set_in(d, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset o_valid",   {31'h0, if0.o_valid},   32'h0);
    chk("reset o_result",  if0.o_result,           32'h0);
    chk("reset o_rd_addr", {27'h0, if0.o_rd_addr}, 32'h0);
    chk("reset o_busy",    {31'h0, if0.o_busy},    32'h0);
    chk("reset o_ready",   {31'h0, if0.o_ready},   32'h1);
    rst_n = 1'b1;

    // First vector is driven at once, so it is accepted on the first edge after reset.
    foreach (vecs[i])
      run_op(vecs[i].d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
             vecs[i].exp, vecs[i].lat, vecs[i].name);

    // Flush and valid together: not accepted.
    set_in(0, 1'b1, OP_MUL, 32'd3, 32'd4, 5'd1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    chk("flush+valid ready", {31'h0, if0.o_ready}, 32'h1);
    chk("flush+valid busy",  {31'h0, if0.o_busy},  32'h0);
    expect_no_valid(0, 40, "flush+valid no result");

    // Flush ten cycles into a divide.
    set_in(0, 1'b1, OP_DIV, 32'd1000, 32'd3, 5'd9, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    chk("div started busy", {31'h0, if0.o_busy}, 32'h1);
    repeat (9) @(negedge clk);
    set_in(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    chk("post-flush ready", {31'h0, if0.o_ready}, 32'h1);
    chk("post-flush busy",  {31'h0, if0.o_busy},  32'h0);
    expect_no_valid(0, 40, "flushed div no result");
    run_op(0, OP_MUL, 32'd6, 32'd7, 5'd3, 32'd42, 33, "MUL after flush");

    // Asynchronous reset in the middle of a divide.
    set_in(0, 1'b1, OP_DIV, 32'd1000, 32'd7, 5'd21, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset o_valid",   {31'h0, if0.o_valid},   32'h0);
    chk("mid reset o_result",  if0.o_result,           32'h0);
    chk("mid reset o_rd_addr", {27'h0, if0.o_rd_addr}, 32'h0);
    chk("mid reset o_busy",    {31'h0, if0.o_busy},    32'h0);
    chk("mid reset o_ready",   {31'h0, if0.o_ready},   32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, OP_DIVU, 32'd100, 32'd7, 5'd4, 32'd14, 33, "DIVU after reset");

    // Randomized operations against the reference model.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 30; n++) begin
        int          xl;
        logic [2:0]  op;
        logic [31:0] a, b;
        xl = (d == 2) ? 16 : 32;
        op = 3'($urandom_range(0, 7));
        a  = pick(xl);
        b  = pick(xl);
        run_op(d, op, a, b, 5'($urandom), ref_result(xl, op, a, b),
               ref_lat(xl, d == 1, op, a, b), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand/result width, legal values 16, 32 and 64.
REQ-002 Parameter FAST_MUL, default 0: 0 = iterative shift-add multiply; 1 = single-cycle multiply.
REQ-003 i_clk  input  1: sole clock; all state updates on rising edge.
REQ-004 i_reset  input  1: one clock; reset is asynchronous and active-low.
REQ-005 i_valid  input  1: request present.
REQ-006 o_ready  output  1: unit can accept a request.
REQ-007 i_op  input  3: funct3 encoding.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 i_rs1  input  XLEN: dividend / multiplicand.
REQ-009 i_rs2  input  XLEN: divisor / multiplier.
REQ-010 i_rd_addr  input  5: destination tag, returned with the result.
REQ-011 i_flush  input  1: kill the in-flight operation (pipeline redirect).
REQ-012 o_valid  output  1: one-cycle result strobe; no backpressure.
REQ-013 o_result  output  XLEN: result.
REQ-014 o_rd_addr  output  5: tag of the result.
REQ-015 o_busy  output  1: operation in flight (state CALC or DONE).

Function
REQ-016 Accept SHALL occur on a rising edge where i_valid && o_ready && !i_flush; operands, op and tag are registered at that edge (edge T).
REQ-017 The FSM SHALL have states IDLE, CALC and DONE; o_ready SHALL equal (state == IDLE).
REQ-018 State transitions:
  - IDLE -> CALC on accept.
  - IDLE -> DONE on accept when a fast path applies (REQ-021/022/023).
  - CALC -> DONE when the iteration counter reaches 0.
  - DONE -> IDLE unconditionally.
REQ-019 The iterative path SHALL process one bit per cycle for XLEN cycles; o_valid SHALL be high in the cycle after edge T+XLEN+1.
REQ-020 o_valid SHALL equal (state == DONE) && !i_flush; it is high for exactly one cycle per accepted, unflushed operation.
REQ-021 Fast path: FAST_MUL=1 with a multiply op SHALL go IDLE -> DONE; o_valid in the cycle after edge T+1.
REQ-022 Fast path: divide by zero.
  - DIV/DIVU SHALL return all-ones.
  - REM/REMU SHALL return the dividend.
  - Latency as REQ-021.
REQ-023 Fast path: signed overflow (dividend = -2^(XLEN-1), divisor = -1).
  - DIV SHALL return the dividend.
  - REM SHALL return 0.
  - Latency as REQ-021.
REQ-024 Signed operands SHALL be converted to magnitudes before iteration; the result sign SHALL be applied in the CALC->DONE edge.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
REQ-025 Multiply SHALL form a full 2*XLEN product.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned semantics respectively.
REQ-026 o_result and o_rd_addr SHALL be registered, updated only on entry to DONE, and held stable until the next entry to DONE.
REQ-027 i_flush high in any state SHALL force IDLE on the next edge and discard the operation.
  - If i_flush and i_valid are high in the same IDLE cycle, flush wins and the request is not accepted.
REQ-028 Inputs SHALL be ignored while o_ready is low.

Reset
REQ-029 Assertion of i_reset (low), including mid-operation, SHALL immediately force:
  - state = IDLE, iteration counter = 0, all datapath registers = 0.
  - o_valid = 0, o_result = 0, o_rd_addr = 0, o_busy = 0, o_ready = 1.
REQ-030 The first accept SHALL be possible on the first rising edge after reset deassertion.

Structure
REQ-031 Package muldiv_pkg SHALL hold:
  - the op enum (funct3 codes);
  - the FSM state enum;
  - the default XLEN constant.
REQ-032 One sub-module, iter_divider, SHALL implement the restoring unsigned divide step (XLEN iterations, quotient/remainder registers); the multiplier SHALL be implemented inline in muldiv_unit.

Verification
REQ-033 MUL 7 × 0xFFFFFFFD (XLEN=32, FAST_MUL=0) -> o_result 0xFFFFFFEB, o_valid after edge T+33, o_rd_addr equals the tag sent.
REQ-034 High-half multiplies (XLEN=32):
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
  - Repeat with FAST_MUL=1 -> o_valid after edge T+1.
REQ-035 Divides (XLEN=32):
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 Special-case divides (XLEN=32):
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - All four -> o_valid after edge T+1.
REQ-037 Flush and reset mid-operation:
  - i_flush 10 cycles into a DIV -> no o_valid; o_ready high next cycle; next MUL accepted and correct.
  - i_reset low mid-DIV -> all outputs 0 immediately.
REQ-038 XLEN=16 instance: DIVU 0xFFFF/0x0010 -> 0x0FFF, o_valid after edge T+17.
